// File: rtl/uart_frame_scheduler.sv
// Periodic board_ID/points frame scheduler feeding two UART transmitters over one shared byte bus.
// Optional checksum byte enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  board_ID,
  input  logic [23:0] points,
  input  logic        tx_busy1,
  input  logic        tx_busy2,
  output logic [7:0]  tx_data,
  output logic        tx_start1,
  output logic        tx_start2,
  output logic        frame_busy,
  output logic        frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned IDX_W = 3;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned LAST  = 4;
`else
  localparam int unsigned LAST  = 3;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         frame_id;
  logic [23:0]        frame_pts;
  logic [IDX_W-1:0]   idx1;
  logic [IDX_W-1:0]   idx2;
  logic [1:0]         guard1;
  logic [1:0]         guard2;
  logic               rr_last2;

  logic               fin1;
  logic               fin2;
  logic               elig1;
  logic               elig2;
  logic               grant1;
  logic               grant2;
  logic [IDX_W-1:0]   sel_idx;
  logic [7:0]         sel_byte;

  assign fin1  = (idx1 == IDX_W'(LAST + 1));
  assign fin2  = (idx2 == IDX_W'(LAST + 1));
  assign elig1 = (state == SEND) && !fin1 && (guard1 == 2'd0) && !tx_busy1;
  assign elig2 = (state == SEND) && !fin2 && (guard2 == 2'd0) && !tx_busy2;

  // Round robin: on contention the channel not granted last wins.
  assign grant1 = elig1 && (!elig2 || rr_last2);
  assign grant2 = elig2 && (!elig1 || !rr_last2);

  // Byte of the snapshot frame addressed by the granted channel's index.
  always_comb begin
    sel_idx  = grant1 ? idx1 : idx2;
    sel_byte = 8'hFF;
    case (sel_idx)
      3'd0:    sel_byte = frame_id;
      3'd1:    sel_byte = frame_pts[23:16];
      3'd2:    sel_byte = frame_pts[15:8];
      3'd3:    sel_byte = frame_pts[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
      3'd4:    sel_byte = frame_id ^ frame_pts[23:16] ^ frame_pts[15:8] ^ frame_pts[7:0];
`endif
      default: sel_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_id   <= '0;
      frame_pts  <= '0;
      idx1       <= '0;
      idx2       <= '0;
      guard1     <= '0;
      guard2     <= '0;
      rr_last2   <= 1'b1;
      tx_data    <= 8'hFF;
      tx_start1  <= 1'b0;
      tx_start2  <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_data    <= 8'hFF;
      tx_start1  <= 1'b0;
      tx_start2  <= 1'b0;
      frame_done <= 1'b0;

      // Guard hides the UART's busy-assert latency after each start.
      if (guard1 != 2'd0) guard1 <= guard1 - 2'd1;
      if (guard2 != 2'd0) guard2 <= guard2 - 2'd1;

      case (state)
        IDLE: begin
          if (cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
            cnt <= '0;
            if (board_ID != 8'd0) begin
              frame_id   <= board_ID;
              frame_pts  <= points;
              idx1       <= '0;
              idx2       <= '0;
              state      <= SEND;
              frame_busy <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SEND: begin
          if (grant1) begin
            tx_start1 <= 1'b1;
            tx_data   <= sel_byte;
            idx1      <= idx1 + IDX_W'(1);
            guard1    <= 2'd2;
            rr_last2  <= 1'b0;
          end else if (grant2) begin
            tx_start2 <= 1'b1;
            tx_data   <= sel_byte;
            idx2      <= idx2 + IDX_W'(1);
            guard2    <= 2'd2;
            rr_last2  <= 1'b1;
          end
          if (fin1 && fin2) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          frame_busy <= 1'b0;
          cnt        <= '0;
        end

        default: begin
          state      <= IDLE;
          frame_busy <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench for uart_frame_scheduler: expected per-channel byte queues are filled by
// the stimulus and drained by a monitor on every start pulse.
module tb_uart_frame_scheduler;

  localparam int unsigned R = 16;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned NB = 5;
`else
  localparam int unsigned NB = 4;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  board_ID;
  logic [23:0] points;
  logic        tx_busy1;
  logic        tx_busy2;
  logic [7:0]  tx_data;
  logic        tx_start1;
  logic        tx_start2;
  logic        frame_busy;
  logic        frame_done;

  uart_frame_scheduler #(.REFRESH_CYCLES(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .board_ID   (board_ID),
    .points     (points),
    .tx_busy1   (tx_busy1),
    .tx_busy2   (tx_busy2),
    .tx_data    (tx_data),
    .tx_start1  (tx_start1),
    .tx_start2  (tx_start2),
    .frame_busy (frame_busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         done_cnt;
  int         cyc;
  int         t_send;
  int         t_first1;
  int         t_last1;
  int         prev_ch;
  bit         alt_en;
  bit         busy_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as seen on the wire: id, score MSB first, optional xor of the four.
  task automatic push_frame(input logic [7:0] id, input logic [23:0] pts);
    logic [7:0] b[5];
    b[0] = id;
    b[1] = pts[23:16];
    b[2] = pts[15:8];
    b[3] = pts[7:0];
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    for (int i = 0; i < int'(NB); i++) begin
      q1.push_back(b[i]);
      q2.push_back(b[i]);
    end
  endtask

  task automatic on_start(input int ch);
    logic [31:0] exp;
    exp = 32'h100;
    if (ch == 1 && q1.size() != 0) exp = 32'(q1.pop_front());
    if (ch == 2 && q2.size() != 0) exp = 32'(q2.pop_front());
    check(ch == 1 ? "ch1_byte" : "ch2_byte", 32'(tx_data), exp);
    if (alt_en && prev_ch != 0) check("alternation", 32'(ch), 32'(3 - prev_ch));
    prev_ch = ch;
    if (ch == 1) begin
      if (t_first1 < 0) t_first1 = cyc;
      t_last1 = cyc;
    end
  endtask

  task automatic mon_step();
    cyc++;
    if (rst) begin
      busy_d = 1'b0;
      return;
    end
    if (frame_busy && !busy_d) t_send = cyc;
    busy_d = frame_busy;
    check("start_exclusive", 32'(tx_start1 & tx_start2), 32'd0);
    if (tx_start1) on_start(1);
    if (tx_start2) on_start(2);
    if (!tx_start1 && !tx_start2) check("bus_idle", 32'(tx_data), 32'hFF);
    if (frame_done) begin
      done_cnt++;
      check("done_all_issued", 32'(q1.size() + q2.size()), 32'd0);
      check("done_in_busy", 32'(frame_busy), 32'd1);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_data", 32'(tx_data), 32'hFF);
    check("rst_tx_start1", 32'(tx_start1), 32'd0);
    check("rst_tx_start2", 32'(tx_start2), 32'd0);
    check("rst_frame_busy", 32'(frame_busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_busy && n < 200);
    check("frame_start_seen", 32'(frame_busy), 32'd1);
  endtask

  task automatic wait_done(input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else if (rnd) begin
        tx_busy1 = ($urandom_range(3, 0) == 0);
        tx_busy2 = ($urandom_range(3, 0) == 0);
      end
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("busy_falls_after_done", 32'(frame_busy), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    int starts;
    logic [7:0]  rid;
    logic [23:0] rpts;

    checks = 0; errors = 0; done_cnt = 0; cyc = 0;
    t_send = -1; t_first1 = -1; t_last1 = -1; prev_ch = 0; alt_en = 1'b0; busy_d = 1'b0;
    rst = 1'b1; board_ID = 8'h05; points = 24'h123456; tx_busy1 = 1'b0; tx_busy2 = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Basic frame: alternating 1,2,... starting on channel 1.
    push_frame(8'h05, 24'h123456);
    alt_en = 1'b1; prev_ch = 2; d0 = done_cnt;
    rst = 1'b0;
    wait_busy(n);
    check("first_frame_latency", 32'(n), 32'(R));
    board_ID = 8'h00;
    wait_done(1'b0);
    repeat (2) @(negedge clk);
    check("basic_done_count", 32'(done_cnt - d0), 32'd1);
    check("basic_first_start", 32'(t_first1), 32'(t_send + 1));

    // Unassigned board: nothing must happen.
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("unassigned_idle", 32'({frame_busy, tx_start1, tx_start2}), 32'd0);
    end
    check("unassigned_no_done", 32'(done_cnt - d0), 32'd0);

    // Stalled channel 2: channel 1 runs at full rate, frame waits for channel 2.
    alt_en = 1'b0; tx_busy2 = 1'b1; board_ID = 8'h05; points = 24'h123456;
    push_frame(8'h05, 24'h123456);
    t_first1 = -1; d0 = done_cnt;
    wait_busy(n);
    board_ID = 8'h00;
    repeat (40) @(negedge clk);
    check("stall_ch1_complete", 32'(q1.size()), 32'd0);
    check("stall_ch2_pending", 32'(q2.size()), 32'(NB));
    check("stall_no_done", 32'(done_cnt - d0), 32'd0);
    check("stall_ch1_first", 32'(t_first1), 32'(t_send + 1));
    check("stall_ch1_rate", 32'(t_last1 - t_first1), 32'(3 * (NB - 1)));
    tx_busy2 = 1'b0;
    wait_done(1'b0);
    repeat (2) @(negedge clk);
    check("stall_done_count", 32'(done_cnt - d0), 32'd1);

    // Snapshot isolation: inputs change after the first start pulse.
    board_ID = 8'h05; points = 24'h123456;
    push_frame(8'h05, 24'h123456);
    d0 = done_cnt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_start1 || tx_start2) && n < 200);
    check("snap_start_seen", 32'(tx_start1 | tx_start2), 32'd1);
    points = 24'hABCDEF; board_ID = 8'h00;
    wait_done(1'b0);
    repeat (2) @(negedge clk);
    check("snap_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset mid-frame: immediate abort, restart from byte0 a full period later.
    board_ID = 8'h05; points = 24'h123456;
    push_frame(8'h05, 24'h123456);
    d0 = done_cnt;
    wait_busy(n);
    starts = 0;
    for (int i = 0; i < 50 && starts < 2; i++) begin
      @(negedge clk);
      if (tx_start1 || tx_start2) starts++;
    end
    check("midframe_two_starts", 32'(starts), 32'd2);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    q1.delete();
    q2.delete();
    push_frame(8'h05, 24'h123456);
    alt_en = 1'b1; prev_ch = 2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_busy(n);
    check("restart_latency", 32'(n), 32'(R));
    board_ID = 8'h00;
    wait_done(1'b0);
    repeat (2) @(negedge clk);
    check("restart_done_count", 32'(done_cnt - d0), 32'd1);
    alt_en = 1'b0;

    // Random frames with random busy activity while sending.
    for (int f = 0; f < 8; f++) begin
      rid  = 8'($urandom_range(255, 1));
      rpts = 24'($urandom);
      board_ID = rid; points = rpts;
      push_frame(rid, rpts);
      d0 = done_cnt;
      wait_busy(n);
      board_ID = 8'h00;
      points = 24'($urandom);
      wait_done(1'b1);
      tx_busy1 = 1'b0; tx_busy2 = 1'b0;
      repeat (2) @(negedge clk);
      check("rand_done_count", 32'(done_cnt - d0), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

- Periodically snapshots the local board identifier and 24-bit score.
- Serialises the snapshot as a fixed byte frame and transmits it to both UART transmitters over one shared `tx_data` bus.
- Both channels progress independently:
  - each is paced by its own `tx_busy`;
  - a round-robin arbiter grants the shared bus to at most one channel per cycle.
- Sits between the game-state logic (board_ID/points) and the two UART TX instances, replacing ad-hoc per-byte start generation.

## Interface
Parameters:
- REFRESH_CYCLES, 1_000_000: idle cycles between frame starts (≥4).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- board_ID  in  8  local board identifier; 0 = unassigned, no frames sent.
- points  in  24  current score, MSB first on the wire.
- tx_busy1  in  1  UART1 transmitter busy.
- tx_busy2  in  1  UART2 transmitter busy.
- tx_data  out  8  shared byte bus; 8'hFF when no byte is issued.
- tx_start1  out  1  one-cycle start pulse to UART1.
- tx_start2  out  1  one-cycle start pulse to UART2.
- frame_busy  out  1  high from frame start until both channels finish.
- frame_done  out  1  one-cycle pulse when both channels have issued the last byte.

## Operation
- **Frame layout:**
  - byte0 = board_ID;
  - byte1 = points[23:16];
  - byte2 = points[15:8];
  - byte3 = points[7:0];
  - optional byte4 = checksum (see Configuration).
- **State machine:**
  - IDLE:
    - refresh counter increments from 0.
    - At count REFRESH_CYCLES-1 the counter clears and the block samples board_ID.
    - If board_ID ≠ 0: snapshot board_ID and points into frame registers, clear both channel byte indices, go to SEND.
    - If board_ID = 0: stay in IDLE; counter restarts.
  - SEND: per-channel sequencing and arbitration as below.
    - When both channels have issued the last byte, go to DONE.
  - DONE: one cycle; frame_done=1; return to IDLE with counter at 0.
- **Per channel n (idx_n 0..LAST, guard_n 2-bit):**
  - eligible_n = SEND && !finished_n && guard_n==0 && tx_busy_n==0.
- **Arbiter:**
  - Only one eligible channel: grant it.
  - Both eligible: grant the channel that was not granted last. The round-robin pointer resets to favour channel 1.
- **Grant to channel n:**
  - next cycle, tx_start_n=1 and tx_data = frame byte idx_n;
  - idx_n increments; guard_n is loaded with 2.
- **Guard:** guard_n decrements each cycle to 0. This masks the UART's busy-assert latency.
- **Bus idle:** tx_data returns to 8'hFF in any cycle with no start pulse.
- **Snapshot isolation:** board_ID and points changes during SEND do not alter the frame in flight.
- **frame_busy:** high in SEND and DONE.

## Timing
- **Reset values:** tx_data=8'hFF; tx_start1=0; tx_start2=0; frame_busy=0; frame_done=0.
- **State on reset:** state=IDLE; counter=0; indices=0; guards=0.
- **Reset mid-frame:** frame is aborted immediately with no further starts. The next frame starts REFRESH_CYCLES cycles after reset release.
- **Output timing:** all outputs are registered. tx_start and tx_data change on the same edge, so data is valid exactly in the start cycle.
- **First frame start:** SEND is entered on the cycle after counter = REFRESH_CYCLES-1.
- **First start pulse:** earliest one cycle after entering SEND.
- **Next byte on the same channel:** if channel n pulses at cycle t, its next pulse is at earliest t+3 (grant at t+2 with busy low).
- **Shared bus:** at most one of tx_start1/tx_start2 is high in any cycle.
- **Busy held high:** the channel stalls indefinitely with no timeout, while the other channel continues.
- **Frame completion:** frame_done is asserted the cycle after the later channel's final start pulse. It is never asserted for a skipped (board_ID=0) period.

## Configuration
- **Macro:** UART_FRAME_CHECKSUM_EN.
- **Defined:**
  - LAST=4, frame is 5 bytes;
  - byte4 = byte0 ^ byte1 ^ byte2 ^ byte3, computed from the snapshot.
- **Undefined:** LAST=3, frame is 4 bytes; no checksum logic is present.

## Test plan
- **Basic frame:** REFRESH_CYCLES=16, board_ID=8'h05, points=24'h123456, busy lines tied 0.
  - Each channel receives 05,12,34,56 in order.
  - Starts alternate 1,2,1,2…
  - Never both high; frame_done pulses once.
- **Unassigned board:** board_ID=0 for 100 cycles → no tx_start pulses; tx_data stays 8'hFF; frame_busy stays 0.
- **Stalled channel:** tx_busy2 held 1.
  - UART1 completes all bytes with no delay from the stall.
  - frame_done stays low until tx_busy2 drops.
  - UART2 then receives 05,12,34,56.
- **Snapshot isolation:** points changes to 24'hABCDEF after the first start pulse → both channels still send 12,34,56.
- **Reset mid-frame:** rst asserted after the second start pulse.
  - Outputs are at reset values in the same cycle.
  - The next frame begins after 16 cycles and restarts at byte0.
- **Checksum build:** with UART_FRAME_CHECKSUM_EN defined and the basic-frame stimulus → each channel receives a fifth byte 8'h05^8'h12^8'h34^8'h56 = 8'h75.
